// File: rtl/div_pkg.sv
// Shared types and helpers for the signed shift-subtract divider.
package div_pkg;
  localparam int DIV_WIDTH = 8;
  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_Q = 8'hFF;

  typedef enum logic [2:0] {IDLE, SETUP, ITER, FIXUP, DONE} div_state_t;

  // Two's-complement magnitude; -128 maps to 8'h80, read as unsigned 128.
  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] x);
    return x[DIV_WIDTH-1] ? (~x + 1'b1) : x;
  endfunction
endpackage

// File: rtl/div_control.sv
// Divider sequencer: IDLE -> SETUP -> ITER x DIV_WIDTH -> FIXUP -> DONE, plus bit counter.
module div_control
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clr_ldb,
  input  logic div_zero,
  output logic start,
  output logic ld_b,
  output logic setup,
  output logic shift_sub,
  output logic fixup,
  output logic busy
);
  localparam int CNT_W = $clog2(DIV_WIDTH);

  div_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == SETUP)     cnt <= CNT_W'(DIV_WIDTH - 1);
      else if (state == ITER) cnt <= cnt - 1'b1;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (!run) state_nx = SETUP;
      SETUP:   state_nx = div_zero ? FIXUP : ITER;
      ITER:    if (cnt == '0) state_nx = FIXUP;
      FIXUP:   state_nx = DONE;
      DONE:    if (run) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Run wins over CLR_LDB when both are pressed in IDLE.
  always_comb begin
    start     = (state == IDLE) && !run;
    ld_b      = (state == IDLE) && run && !clr_ldb;
    setup     = (state == SETUP);
    shift_sub = (state == ITER);
    fixup     = (state == FIXUP);
    busy      = (state == SETUP) || (state == ITER) || (state == FIXUP);
  end
endmodule

// File: rtl/signed_8bit_divider.sv
// Sequential signed divider for the switch/pushbutton panel; quotient on B_out, remainder on A_out.
// Optional DivZero status port is enabled by defining DIV_STATUS_EN.
module signed_8bit_divider
  import div_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 CLR_LDB,
  input  logic [DIV_WIDTH-1:0] Switches,
  output logic [DIV_WIDTH-1:0] A_out,
  output logic [DIV_WIDTH-1:0] B_out,
`ifdef DIV_STATUS_EN
  output logic                 DivZero,
`endif
  output logic                 Busy
);
  localparam int W  = DIV_WIDTH;
  localparam int RW = W + 1;

  logic         start, ld_b, setup, shift_sub, fixup;
  logic [W-1:0] d, q, m;
  logic [RW-1:0] r;
  logic         sq, sr, dz;
  logic [W+1:0] rs;
  logic         ge;

  div_control u_ctrl (
    .clk      (Clk),
    .rst      (Reset),
    .run      (Run),
    .clr_ldb  (CLR_LDB),
    .div_zero (d == '0),
    .start    (start),
    .ld_b     (ld_b),
    .setup    (setup),
    .shift_sub(shift_sub),
    .fixup    (fixup),
    .busy     (Busy)
  );

  // One restoring step: shift {R,Q} left, subtract M when it fits.
  assign rs = {r, q[W-1]};
  assign ge = rs >= {2'b00, m};

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      A_out <= '0;
      B_out <= '0;
      d     <= '0;
      q     <= '0;
      m     <= '0;
      r     <= '0;
      sq    <= 1'b0;
      sr    <= 1'b0;
      dz    <= 1'b0;
    end else begin
      if (start) d <= Switches;
      if (ld_b) begin
        B_out <= Switches;
        A_out <= '0;
      end
      if (setup) begin
        sq <= B_out[W-1] ^ d[W-1];
        sr <= B_out[W-1];
        dz <= (d == '0);
        m  <= abs_val(d);
        if (d == '0) begin
          q <= DIV_ZERO_Q;
          r <= {1'b0, abs_val(B_out)};
        end else begin
          q <= abs_val(B_out);
          r <= '0;
        end
      end
      if (shift_sub) begin
        r <= RW'(ge ? rs - {2'b00, m} : rs);
        q <= {q[W-2:0], ge};
      end
      if (fixup) begin
        if (dz) begin
          B_out <= DIV_ZERO_Q;
          A_out <= r[W-1:0];
        end else begin
          B_out <= sq ? (~q + 1'b1) : q;
          A_out <= sr ? (~r[W-1:0] + 1'b1) : r[W-1:0];
        end
      end
    end
  end

`ifdef DIV_STATUS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset)      DivZero <= 1'b0;
    else if (setup) DivZero <= 1'b0;
    else if (fixup) DivZero <= dz;
  end
`endif
endmodule

// File: tb/tb_signed_8bit_divider.sv
// Self-checking bench for signed_8bit_divider: directed cases plus random operands vs. integer division.
module tb_signed_8bit_divider;
  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       Run = 1'b1;
  logic       CLR_LDB = 1'b1;
  logic [7:0] Switches = '0;
  logic [7:0] A_out, B_out;
  logic       Busy;
`ifdef DIV_STATUS_EN
  logic       DivZero;
`endif

  int tests = 0;
  int fails = 0;

  signed_8bit_divider dut (
    .Clk(Clk), .Reset(Reset), .Run(Run), .CLR_LDB(CLR_LDB), .Switches(Switches),
    .A_out(A_out), .B_out(B_out),
`ifdef DIV_STATUS_EN
    .DivZero(DivZero),
`endif
    .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [7:0] v);
    @(negedge Clk); Switches = v; CLR_LDB = 1'b0;
    @(posedge Clk); #1;
    chk("load_b", B_out, v);
    chk("load_a", A_out, 8'h00);
    @(negedge Clk); CLR_LDB = 1'b1;
  endtask

  // Press Run with divisor dvs; scribble on Switches/CLR_LDB while busy to show they are ignored.
  task automatic divide(input string tag, input logic [7:0] dvd, input logic [7:0] dvs,
                        input int lat, input bit clr_too);
    int a, b, qi, ri;
    logic [7:0] eq, er;
    a = int'($signed(dvd));
    b = int'($signed(dvs));
    if (b == 0) begin
      eq = 8'hFF;
      er = dvd;
    end else begin
      qi = a / b;
      ri = a % b;
      eq = qi[7:0];
      er = ri[7:0];
    end
    @(negedge Clk); Switches = dvs; Run = 1'b0; CLR_LDB = clr_too ? 1'b0 : 1'b1;
    @(posedge Clk);
    @(negedge Clk); Run = 1'b1; Switches = 8'($urandom); CLR_LDB = 1'b0;
    @(posedge Clk);
    @(negedge Clk); CLR_LDB = 1'b1;
    repeat (lat - 2) @(posedge Clk);
    #1;
    chk({tag, "_busy_mid"}, {7'b0, Busy}, 8'h01);
    chk({tag, "_hold_b"}, B_out, dvd);
    @(posedge Clk); #1;
    chk({tag, "_q"}, B_out, eq);
    chk({tag, "_r"}, A_out, er);
    chk({tag, "_busy_end"}, {7'b0, Busy}, 8'h00);
    @(posedge Clk); #1;
  endtask

  initial begin
    #12;
    chk("rst_a", A_out, 8'h00);
    chk("rst_b", B_out, 8'h00);
    chk("rst_busy", {7'b0, Busy}, 8'h00);
`ifdef DIV_STATUS_EN
    chk("rst_dz", {7'b0, DivZero}, 8'h00);
`endif
    @(negedge Clk); Reset = 1'b0;

    load(8'd7);   divide("7_2", 8'd7, 8'd2, 10, 1'b0);
    load(8'hF9);  divide("m7_2", 8'hF9, 8'd2, 10, 1'b0);
    load(8'd33);  divide("33_m3", 8'd33, 8'hFD, 10, 1'b0);
    load(8'h80);  divide("ovf", 8'h80, 8'hFF, 10, 1'b0);
    load(8'd5);   divide("dz", 8'd5, 8'd0, 2, 1'b0);
`ifdef DIV_STATUS_EN
    chk("dz_flag", {7'b0, DivZero}, 8'h01);
`endif
    load(8'd20);  divide("prio", 8'd20, 8'd3, 10, 1'b1);
`ifdef DIV_STATUS_EN
    chk("dz_clear", {7'b0, DivZero}, 8'h00);
`endif

    for (int i = 0; i < 24; i++) begin
      logic [7:0] x, y;
      x = 8'($urandom);
      y = 8'($urandom_range(1, 255));
      load(x);
      divide("rand", x, y, 10, 1'b0);
    end

    // Reset in the middle of the iterations
    load(8'd7);
    @(negedge Clk); Switches = 8'd2; Run = 1'b0;
    @(posedge Clk);
    @(negedge Clk); Run = 1'b1;
    repeat (4) @(posedge Clk);
    #1; Reset = 1'b1; #1;
    chk("abort_a", A_out, 8'h00);
    chk("abort_b", B_out, 8'h00);
    chk("abort_busy", {7'b0, Busy}, 8'h00);
    @(negedge Clk); Reset = 1'b0;

    // Holding Run low past DONE must not start a second division
    load(8'd7);
    @(negedge Clk); Switches = 8'd2; Run = 1'b0;
    @(posedge Clk);
    repeat (10) @(posedge Clk);
    #1;
    chk("hold_q", B_out, 8'd3);
    chk("hold_r", A_out, 8'd1);
    chk("hold_busy", {7'b0, Busy}, 8'h00);
    @(negedge Clk); Switches = 8'd9;
    repeat (5) @(posedge Clk);
    #1;
    chk("hold2_q", B_out, 8'd3);
    chk("hold2_r", A_out, 8'd1);
    chk("hold2_busy", {7'b0, Busy}, 8'h00);
    @(negedge Clk); Run = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    chk("release_busy", {7'b0, Busy}, 8'h00);
    chk("release_q", B_out, 8'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end
endmodule
